// File: rtl/rs_issue_queue_pkg.sv
// Shared types for the reservation-station issue queue: operand and entry
// records, default widths, and the dispatch-time operand capture helper.
package rs_issue_queue_pkg;

    localparam int DATA_W = 64;   // operand/result width
    localparam int TAG_W  = 4;    // ROB tag width
    localparam int OPC_W  = 5;    // FU opcode width

    // One source operand: either a ready value or a pending producer tag.
    typedef struct packed {
        logic              rdy;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } rs_operand_t;

    // One reservation-station slot.
    typedef struct packed {
        logic             valid;
        logic [OPC_W-1:0] op;
        logic [TAG_W-1:0] dst;
        rs_operand_t      op1;
        rs_operand_t      op2;
    } rs_issue_entry_t;

    // Build an operand at dispatch, taking a same-cycle CDB broadcast of the
    // producer tag so the result is not missed between dispatch and wakeup.
    function automatic rs_operand_t capture_operand(
        input logic              present,
        input logic [TAG_W-1:0]  tag,
        input logic [DATA_W-1:0] value,
        input logic              cdb_valid,
        input logic [TAG_W-1:0]  cdb_tag,
        input logic [DATA_W-1:0] cdb_value
    );
        rs_operand_t opnd;
        opnd.tag   = tag;
        opnd.rdy   = present || (cdb_valid && (cdb_tag == tag));
        opnd.value = present ? value : cdb_value;
        return opnd;
    endfunction

endpackage

// File: rtl/rs_oldest_select.sv
// Age matrix plus oldest-ready selection. Row i bit j set means entry j is
// older than entry i; the grant is the ready entry with no older ready entry.
module rs_oldest_select #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         flush,
    input  logic [N-1:0] alloc,    // one-hot slot being allocated, or zero
    input  logic [N-1:0] valid,    // registered valid vector
    input  logic [N-1:0] ready,    // valid entries with both operands ready
    output logic [N-1:0] grant     // one-hot oldest ready entry
);

    logic [N-1:0][N-1:0] age_reg;

    // New entry is younger than everything currently valid: its row takes the
    // valid vector and its column is cleared in every other row.
    always_ff @(posedge clk) begin
        if (srst || flush) begin
            age_reg <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (alloc[k]) begin
                    age_reg[k] <= valid;
                end else begin
                    age_reg[k] <= age_reg[k] & ~alloc;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_grant
            assign grant[gi] = ready[gi] && ((age_reg[gi] & ready) == '0);
        end
    endgenerate

endmodule

// File: rtl/rs_issue_queue.sv
// Reservation-station issue queue: allocates dispatched ops into the lowest
// free slot, wakes pending operands from the CDB, and issues the oldest
// fully-ready entry to the FU over a valid/ready handshake.
module rs_issue_queue
    import rs_issue_queue_pkg::*;
#(
    parameter int RS_SIZE      = 8,
    parameter int GPR_SIZE     = DATA_W,
    parameter int ROB_IDX_SIZE = TAG_W,
    parameter int OP_SIZE      = OPC_W
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_flush,
    input  logic                    in_d_valid,
    input  logic [OP_SIZE-1:0]      in_d_op,
    input  logic [ROB_IDX_SIZE-1:0] in_d_dst_rob_idx,
    input  logic                    in_d_op1_valid,
    input  logic [ROB_IDX_SIZE-1:0] in_d_op1_rob_idx,
    input  logic [GPR_SIZE-1:0]     in_d_op1_value,
    input  logic                    in_d_op2_valid,
    input  logic [ROB_IDX_SIZE-1:0] in_d_op2_rob_idx,
    input  logic [GPR_SIZE-1:0]     in_d_op2_value,
    output logic                    out_d_full,
    input  logic                    in_cdb_valid,
    input  logic [ROB_IDX_SIZE-1:0] in_cdb_rob_idx,
    input  logic [GPR_SIZE-1:0]     in_cdb_value,
    output logic                    out_fu_valid,
    input  logic                    in_fu_ready,
    output logic [OP_SIZE-1:0]      out_fu_op,
    output logic [GPR_SIZE-1:0]     out_fu_op1,
    output logic [GPR_SIZE-1:0]     out_fu_op2,
    output logic [ROB_IDX_SIZE-1:0] out_fu_dst_rob_idx
);

    rs_issue_entry_t entry_reg [RS_SIZE];

    logic [RS_SIZE-1:0] valid_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic [RS_SIZE-1:0] free_onehot;
    logic [RS_SIZE-1:0] alloc_onehot;
    logic [RS_SIZE-1:0] grant;
    logic               alloc;
    logic               issue;
    rs_issue_entry_t    new_entry;

    logic [OP_SIZE-1:0]      sel_op;
    logic [GPR_SIZE-1:0]     sel_op1;
    logic [GPR_SIZE-1:0]     sel_op2;
    logic [ROB_IDX_SIZE-1:0] sel_dst;

    generate
        for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_status
            assign valid_vec[gi] = entry_reg[gi].valid;
            assign ready_vec[gi] = entry_reg[gi].valid && entry_reg[gi].op1.rdy
                                   && entry_reg[gi].op2.rdy;
        end
    endgenerate

    // Lowest-index free slot; scanning downward lets the lowest one win.
    always_comb begin
        free_onehot = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                free_onehot = RS_SIZE'(1) << i;
            end
        end
    end

    assign out_d_full   = &valid_vec;
    assign alloc        = in_d_valid && !out_d_full && !in_flush;
    assign alloc_onehot = alloc ? free_onehot : '0;
    assign issue        = out_fu_valid && in_fu_ready;

    rs_oldest_select #(
        .N (RS_SIZE)
    ) u_select (
        .clk   (in_clk),
        .srst  (in_rst),
        .flush (in_flush),
        .alloc (alloc_onehot),
        .valid (valid_vec),
        .ready (ready_vec),
        .grant (grant)
    );

    // Dispatch record, with same-cycle CDB bypass on pending operands.
    always_comb begin
        new_entry.valid = 1'b1;
        new_entry.op    = in_d_op;
        new_entry.dst   = in_d_dst_rob_idx;
        new_entry.op1   = capture_operand(in_d_op1_valid, in_d_op1_rob_idx, in_d_op1_value,
                                          in_cdb_valid, in_cdb_rob_idx, in_cdb_value);
        new_entry.op2   = capture_operand(in_d_op2_valid, in_d_op2_rob_idx, in_d_op2_value,
                                          in_cdb_valid, in_cdb_rob_idx, in_cdb_value);
    end

    // Mux out the granted entry (grant is one-hot or zero).
    always_comb begin
        sel_op  = '0;
        sel_op1 = '0;
        sel_op2 = '0;
        sel_dst = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (grant[i]) begin
                sel_op  = entry_reg[i].op;
                sel_op1 = entry_reg[i].op1.value;
                sel_op2 = entry_reg[i].op2.value;
                sel_dst = entry_reg[i].dst;
            end
        end
    end

    assign out_fu_valid       = (|ready_vec) && !in_flush;
    assign out_fu_op          = out_fu_valid ? sel_op  : '0;
    assign out_fu_op1         = out_fu_valid ? sel_op1 : '0;
    assign out_fu_op2         = out_fu_valid ? sel_op2 : '0;
    assign out_fu_dst_rob_idx = out_fu_valid ? sel_dst : '0;

    // Entry state: reset/flush clear, otherwise allocate, free on issue, wake up.
    always_ff @(posedge in_clk) begin
        if (in_rst || in_flush) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (alloc_onehot[i]) begin
                    entry_reg[i] <= new_entry;
                end else begin
                    if (issue && grant[i]) begin
                        entry_reg[i].valid <= 1'b0;
                    end
                    if (entry_reg[i].valid && !entry_reg[i].op1.rdy && in_cdb_valid
                        && (entry_reg[i].op1.tag == in_cdb_rob_idx)) begin
                        entry_reg[i].op1.rdy   <= 1'b1;
                        entry_reg[i].op1.value <= in_cdb_value;
                    end
                    if (entry_reg[i].valid && !entry_reg[i].op2.rdy && in_cdb_valid
                        && (entry_reg[i].op2.tag == in_cdb_rob_idx)) begin
                        entry_reg[i].op2.rdy   <= 1'b1;
                        entry_reg[i].op2.value <= in_cdb_value;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_issue_queue.sv
// Bench for rs_issue_queue: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against an age-ordered
// queue model of the reservation station.
module tb_rs_issue_queue;

    localparam int RS = 8;
    localparam int GW = 64;
    localparam int TW = 4;
    localparam int OW = 5;

    logic          clk = 1'b0;
    logic          in_rst, in_flush, in_d_valid;
    logic [OW-1:0] in_d_op;
    logic [TW-1:0] in_d_dst_rob_idx;
    logic          in_d_op1_valid, in_d_op2_valid;
    logic [TW-1:0] in_d_op1_rob_idx, in_d_op2_rob_idx;
    logic [GW-1:0] in_d_op1_value, in_d_op2_value;
    logic          out_d_full;
    logic          in_cdb_valid;
    logic [TW-1:0] in_cdb_rob_idx;
    logic [GW-1:0] in_cdb_value;
    logic          out_fu_valid, in_fu_ready;
    logic [OW-1:0] out_fu_op;
    logic [GW-1:0] out_fu_op1, out_fu_op2;
    logic [TW-1:0] out_fu_dst_rob_idx;

    always #5 clk = ~clk;

    rs_issue_queue #(
        .RS_SIZE      (RS),
        .GPR_SIZE     (GW),
        .ROB_IDX_SIZE (TW),
        .OP_SIZE      (OW)
    ) dut (
        .in_clk             (clk),
        .in_rst             (in_rst),
        .in_flush           (in_flush),
        .in_d_valid         (in_d_valid),
        .in_d_op            (in_d_op),
        .in_d_dst_rob_idx   (in_d_dst_rob_idx),
        .in_d_op1_valid     (in_d_op1_valid),
        .in_d_op1_rob_idx   (in_d_op1_rob_idx),
        .in_d_op1_value     (in_d_op1_value),
        .in_d_op2_valid     (in_d_op2_valid),
        .in_d_op2_rob_idx   (in_d_op2_rob_idx),
        .in_d_op2_value     (in_d_op2_value),
        .out_d_full         (out_d_full),
        .in_cdb_valid       (in_cdb_valid),
        .in_cdb_rob_idx     (in_cdb_rob_idx),
        .in_cdb_value       (in_cdb_value),
        .out_fu_valid       (out_fu_valid),
        .in_fu_ready        (in_fu_ready),
        .out_fu_op          (out_fu_op),
        .out_fu_op1         (out_fu_op1),
        .out_fu_op2         (out_fu_op2),
        .out_fu_dst_rob_idx (out_fu_dst_rob_idx)
    );

    // Model: entries kept oldest-first; slot indices are irrelevant to it.
    typedef struct {
        logic [OW-1:0] op;
        logic [TW-1:0] dst;
        logic          r1;
        logic [TW-1:0] t1;
        logic [GW-1:0] v1;
        logic          r2;
        logic [TW-1:0] t2;
        logic [GW-1:0] v2;
    } m_entry_t;

    m_entry_t mq[$];
    int       total = 0;
    int       bad   = 0;
    bit       known = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        in_rst           = 1'b0;
        in_flush         = 1'b0;
        in_d_valid       = 1'b0;
        in_d_op          = '0;
        in_d_dst_rob_idx = '0;
        in_d_op1_valid   = 1'b1;
        in_d_op1_rob_idx = '0;
        in_d_op1_value   = '0;
        in_d_op2_valid   = 1'b1;
        in_d_op2_rob_idx = '0;
        in_d_op2_value   = '0;
        in_cdb_valid     = 1'b0;
        in_cdb_rob_idx   = '0;
        in_cdb_value     = '0;
        in_fu_ready      = 1'b1;
    endtask

    task automatic disp(input logic [OW-1:0] op, input logic [TW-1:0] dst,
                        input logic v1, input logic [TW-1:0] t1, input logic [GW-1:0] x1,
                        input logic v2, input logic [TW-1:0] t2, input logic [GW-1:0] x2);
        in_d_valid       = 1'b1;
        in_d_op          = op;
        in_d_dst_rob_idx = dst;
        in_d_op1_valid   = v1;
        in_d_op1_rob_idx = t1;
        in_d_op1_value   = x1;
        in_d_op2_valid   = v2;
        in_d_op2_rob_idx = t2;
        in_d_op2_value   = x2;
    endtask

    task automatic rand_inputs();
        in_rst           = ($urandom_range(0, 199) == 0);
        in_flush         = ($urandom_range(0, 59) == 0);
        in_d_valid       = ($urandom_range(0, 9) < 6);
        in_d_op          = OW'($urandom());
        in_d_dst_rob_idx = TW'($urandom());
        in_d_op1_valid   = ($urandom_range(0, 1) == 1);
        in_d_op1_rob_idx = TW'($urandom());
        in_d_op1_value   = {$urandom(), $urandom()};
        in_d_op2_valid   = ($urandom_range(0, 1) == 1);
        in_d_op2_rob_idx = TW'($urandom());
        in_d_op2_value   = {$urandom(), $urandom()};
        in_cdb_valid     = ($urandom_range(0, 9) < 5);
        in_cdb_rob_idx   = TW'($urandom());
        in_cdb_value     = {$urandom(), $urandom()};
        in_fu_ready      = ($urandom_range(0, 9) < 7);
    endtask

    // Called at a falling edge with inputs applied: compare, clock, update model.
    task automatic cycle();
        int            sel;
        logic          ev;
        logic          was_full;
        logic [OW-1:0] e_op;
        logic [GW-1:0] e_op1, e_op2;
        logic [TW-1:0] e_dst;
        m_entry_t      ne;
        #1;
        sel = -1;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].r1 && mq[i].r2) begin
                sel = i;
                break;
            end
        end
        ev    = (sel >= 0) && !in_flush;
        e_op  = '0;
        e_op1 = '0;
        e_op2 = '0;
        e_dst = '0;
        if (ev) begin
            e_op  = mq[sel].op;
            e_op1 = mq[sel].v1;
            e_op2 = mq[sel].v2;
            e_dst = mq[sel].dst;
        end
        was_full = (mq.size() == RS);
        if (known) begin
            chk("d_full",   64'(out_d_full),         64'(was_full));
            chk("fu_valid", 64'(out_fu_valid),       64'(ev));
            chk("fu_op",    64'(out_fu_op),          64'(e_op));
            chk("fu_op1",   out_fu_op1,              e_op1);
            chk("fu_op2",   out_fu_op2,              e_op2);
            chk("fu_dst",   64'(out_fu_dst_rob_idx), 64'(e_dst));
        end
        @(posedge clk);
        if (in_rst || in_flush) begin
            mq.delete();
            known = 1'b1;
        end else begin
            for (int i = 0; i < mq.size(); i++) begin
                if (in_cdb_valid && !mq[i].r1 && mq[i].t1 == in_cdb_rob_idx) begin
                    mq[i].r1 = 1'b1;
                    mq[i].v1 = in_cdb_value;
                end
                if (in_cdb_valid && !mq[i].r2 && mq[i].t2 == in_cdb_rob_idx) begin
                    mq[i].r2 = 1'b1;
                    mq[i].v2 = in_cdb_value;
                end
            end
            if (ev && in_fu_ready) begin
                $display("issue dst=%0d op=%0d op1=%0h op2=%0h", e_dst, e_op, e_op1, e_op2);
                mq.delete(sel);
            end
            if (in_d_valid && !was_full) begin
                ne.op  = in_d_op;
                ne.dst = in_d_dst_rob_idx;
                ne.t1  = in_d_op1_rob_idx;
                ne.r1  = in_d_op1_valid || (in_cdb_valid && in_cdb_rob_idx == in_d_op1_rob_idx);
                ne.v1  = in_d_op1_valid ? in_d_op1_value : in_cdb_value;
                ne.t2  = in_d_op2_rob_idx;
                ne.r2  = in_d_op2_valid || (in_cdb_valid && in_cdb_rob_idx == in_d_op2_rob_idx);
                ne.v2  = in_d_op2_valid ? in_d_op2_value : in_cdb_value;
                mq.push_back(ne);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        in_rst = 1'b1;
        cycle();
        cycle();

        // Reset state
        idle();
        #1;
        chk("rst_full",  64'(out_d_full),         64'd0);
        chk("rst_valid", 64'(out_fu_valid),       64'd0);
        chk("rst_op",    64'(out_fu_op),          64'd0);
        chk("rst_op1",   out_fu_op1,              64'd0);
        chk("rst_dst",   64'(out_fu_dst_rob_idx), 64'd0);

        // Ready dispatch issues the next cycle
        disp(3, 5, 1, 0, 10, 1, 0, 20);
        cycle();
        idle();
        #1;
        chk("t1_valid", 64'(out_fu_valid),       64'd1);
        chk("t1_op",    64'(out_fu_op),          64'd3);
        chk("t1_op1",   out_fu_op1,              64'd10);
        chk("t1_op2",   out_fu_op2,              64'd20);
        chk("t1_dst",   64'(out_fu_dst_rob_idx), 64'd5);
        cycle();
        #1;
        chk("t1_after", 64'(out_fu_valid), 64'd0);

        // CDB wakeup of a pending op1
        disp(1, 2, 0, 7, 0, 1, 0, 1);
        cycle();
        idle();
        #1;
        chk("t2_wait", 64'(out_fu_valid), 64'd0);
        cycle();
        in_cdb_valid   = 1'b1;
        in_cdb_rob_idx = 7;
        in_cdb_value   = 64'hABCD;
        cycle();
        idle();
        #1;
        chk("t2_valid", 64'(out_fu_valid),       64'd1);
        chk("t2_op1",   out_fu_op1,              64'hABCD);
        chk("t2_dst",   64'(out_fu_dst_rob_idx), 64'd2);
        cycle();

        // Same-cycle dispatch bypass on op2
        disp(2, 6, 1, 0, 5, 0, 4, 0);
        in_cdb_valid   = 1'b1;
        in_cdb_rob_idx = 4;
        in_cdb_value   = 64'd99;
        cycle();
        idle();
        #1;
        chk("t3_valid", 64'(out_fu_valid), 64'd1);
        chk("t3_op2",   out_fu_op2,        64'd99);
        cycle();

        // Age order under FU back-pressure
        for (int k = 1; k <= 3; k++) begin
            idle();
            in_fu_ready = 1'b0;
            disp(0, TW'(k), 1, 0, 64'(k), 1, 0, 0);
            if (k > 1) begin
                #1;
                chk("t4_hold", 64'(out_fu_dst_rob_idx), 64'd1);
            end
            cycle();
        end
        idle();
        in_fu_ready = 1'b0;
        #1;
        chk("t4_hold", 64'(out_fu_dst_rob_idx), 64'd1);
        cycle();
        for (int k = 1; k <= 3; k++) begin
            idle();
            #1;
            chk("t4_order", 64'(out_fu_dst_rob_idx), 64'(k));
            cycle();
        end
        #1;
        chk("t4_empty", 64'(out_fu_valid), 64'd0);

        // Full queue drops dispatch; one issue frees a slot
        for (int k = 0; k < RS; k++) begin
            idle();
            disp(0, TW'(k), 0, 9, 0, 1, 0, 0);
            cycle();
        end
        idle();
        #1;
        chk("t5_full",  64'(out_d_full),   64'd1);
        chk("t5_valid", 64'(out_fu_valid), 64'd0);
        disp(0, 15, 1, 0, 0, 1, 0, 0);
        cycle();
        idle();
        in_cdb_valid   = 1'b1;
        in_cdb_rob_idx = 9;
        in_cdb_value   = 64'h55;
        cycle();
        idle();
        #1;
        chk("t5_still_full", 64'(out_d_full),         64'd1);
        chk("t5_first",      64'(out_fu_dst_rob_idx), 64'd0);
        chk("t5_wake",       out_fu_op1,              64'h55);
        cycle();
        #1;
        chk("t5_not_full", 64'(out_d_full), 64'd0);
        for (int k = 1; k < RS; k++) begin
            #1;
            chk("t5_drain", 64'(out_fu_dst_rob_idx), 64'(k));
            cycle();
        end
        #1;
        chk("t5_dropped", 64'(out_fu_valid), 64'd0);

        // Flush wins over a same-cycle dispatch
        for (int k = 0; k < 3; k++) begin
            idle();
            in_fu_ready = 1'b0;
            disp(0, TW'(k), 1, 0, 0, 1, 0, 0);
            cycle();
        end
        idle();
        in_flush = 1'b1;
        disp(0, 12, 1, 0, 0, 1, 0, 0);
        #1;
        chk("t6_flush_valid", 64'(out_fu_valid), 64'd0);
        cycle();
        idle();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t6_valid", 64'(out_fu_valid), 64'd0);
            chk("t6_full",  64'(out_d_full),   64'd0);
            cycle();
        end

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            rand_inputs();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
